// File: rtl/fp_arb_pkg.sv
// Shared definitions for the floating-point add/sub arbiter: FSM states,
// opcode encodings and default datapath width.
package fp_arb_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } arb_state_e;

  localparam logic OP_ADD   = 1'b0;
  localparam logic OP_SUB   = 1'b1;
  localparam int   FP_W_DEF = 32;

endpackage

// File: rtl/fp_rr_arbiter.sv
// Round-robin picker: the first valid requester after ptr (wrapping) wins.
// Produces a one-hot grant, its index and an any-grant flag.
module fp_rr_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  int cand;

  // Offsets start at 1 so the last winner has the lowest priority.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (en && !any && req[cand]) begin
        any         = 1'b1;
        idx         = IW'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Shares one single-precision add/sub unit between NUM_REQ requesters with
// round-robin issue, tag tracking and hold/drain. FP_ARB_STATS_EN adds grant counters.
module fp_addsub_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 1,
  parameter int FP_W    = FP_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]      req_op,
  output logic [FP_W-1:0]         fpu_a,
  output logic [FP_W-1:0]         fpu_b,
  output logic                    fpu_op,
  input  logic [FP_W-1:0]         fpu_result,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [FP_W-1:0]         resp_data,
  input  logic                    hold,
  output logic                    busy,
  output logic                    idle,
`ifdef FP_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0]   grant_count,
`endif
  output logic [1:0]              state_dbg
);

  localparam int IW = $clog2(NUM_REQ);

  // Handshake: a requester transfers in any cycle where req_valid[i] & req_ready[i];
  // req_ready is at most one-hot and never waits on anything downstream.
  arb_state_e           state;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        gnt_idx;
  logic [NUM_REQ-1:0]   gnt;
  logic                 gnt_any;
  logic                 xfer;
  logic                 arb_en;
  logic [FP_W-1:0]      last_a;
  logic [FP_W-1:0]      last_b;
  logic                 last_op;
  logic [LATENCY-1:0]   vld_pipe;
  logic [IW-1:0]        tag_pipe [LATENCY];

  assign arb_en = (state == RUN) && !hold && !rst;

  fp_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (arb_en),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign req_ready = gnt;
  assign xfer      = gnt_any;

  // Idle cycles replay the last granted operands so the adder never sees X.
  assign fpu_a  = xfer ? req_a[gnt_idx*FP_W +: FP_W] : last_a;
  assign fpu_b  = xfer ? req_b[gnt_idx*FP_W +: FP_W] : last_b;
  assign fpu_op = xfer ? req_op[gnt_idx] : last_op;

  assign busy      = |vld_pipe;
  assign idle      = (state == HALTED);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      rr_ptr     <= IW'(NUM_REQ - 1);
      last_a     <= '0;
      last_b     <= '0;
      last_op    <= OP_ADD;
      vld_pipe   <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      for (int i = 0; i < LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      case (state)
        RUN:     if (hold)  state <= DRAIN;
        DRAIN:   if (!busy) state <= HALTED;
        HALTED:  if (!hold) state <= RUN;
        default: state <= RUN;
      endcase

      if (xfer) begin
        rr_ptr  <= gnt_idx;
        last_a  <= fpu_a;
        last_b  <= fpu_b;
        last_op <= fpu_op;
      end

      vld_pipe[0] <= xfer;
      tag_pipe[0] <= gnt_idx;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end

      // The last pipe stage lines up with the cycle fpu_result is valid.
      resp_valid <= '0;
      if (vld_pipe[LATENCY-1]) begin
        resp_valid[tag_pipe[LATENCY-1]] <= 1'b1;
        resp_data                       <= fpu_result;
      end
    end
  end

`ifdef FP_ARB_STATS_EN
  logic [15:0] grant_cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
    end else if (xfer && (grant_cnt[gnt_idx] != 16'hFFFF)) begin
      grant_cnt[gnt_idx] <= grant_cnt[gnt_idx] + 16'd1;
    end
  end

  always_comb begin
    grant_count = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_count[i*16 +: 16] = grant_cnt[i];
  end
`endif

endmodule
